// File: rtl/dmem_arbiter.sv
// Data memory arbiter: CPU MEM stage (port 0) vs DMA/loader (port 1).
// CPU wins by default; a starvation counter forces an occasional DMA grant.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]        starve_cnt;
  logic              rv0_q;
  logic              rv1_q;
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;

  logic at_limit;
  logic win_starve;
  logic win_p0;
  logic win_p1;
  logic sel0;
  logic sel1;
  logic rd0_go;
  logic rd1_go;

  assign at_limit   = (starve_cnt == LIMIT);
  assign win_starve = rst_n & p1_req & at_limit;
  assign win_p0     = rst_n & p0_req & ~win_starve;
  assign win_p1     = rst_n & p1_req & ~p0_req & ~win_starve;

  // The three win terms are mutually exclusive by construction
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    unique case (1'b1)
      win_starve: sel1 = 1'b1;
      win_p0:     sel0 = 1'b1;
      win_p1:     sel1 = 1'b1;
      default: begin
        sel0 = 1'b0;
        sel1 = 1'b0;
      end
    endcase
  end

  assign p0_gnt = sel0;
  assign p1_gnt = sel1;

  assign rd0_go = sel0 & ~p0_we;
  assign rd1_go = sel1 & ~p1_we;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel0) begin
      mem_read  = ~p0_we;
      mem_write = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (sel1) begin
      mem_read  = ~p1_we;
      mem_write = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  assign cpu_stall = rst_n & p0_req & ~sel0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
    end else begin
      rv0_q <= rd0_go;
      rv1_q <= rd1_go;
      if (rd0_go) rd0_q <= mem_rdata;
      if (rd1_go) rd1_q <= mem_rdata;
      if (!p1_req || sel1) begin
        starve_cnt <= '0;
      end else if (!at_limit) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  // Responses are masked during reset so a pending rvalid is discarded
  assign p0_rvalid = rv0_q & rst_n;
  assign p1_rvalid = rv1_q & rst_n;
  assign p0_rdata  = rst_n ? rd0_q : '0;
  assign p1_rdata  = rst_n ? rd1_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, reset corner cases,
// and randomized traffic against a behavioural model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_read, mem_write, cpu_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  assign mem_rdata = mem_read ? tb_mem[mem_addr[9:2]]
                              : 32'hDEADBEEF;

  always @(posedge clk)
    if (mem_write) tb_mem[mem_addr[9:2]] = mem_wdata;

  typedef struct {
    logic [31:0] r0, w0, a0, d0;
    logic [31:0] r1, w1, a1, d1;
    logic [31:0] g0, g1, st, mr, mw;
    logic [31:0] ma, md;
    logic [31:0] v0, v1, rd0, rd1;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    p0_req = 1'b0; p0_we = 1'b0;
    p0_addr = '0;  p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0;
    p1_addr = '0;  p1_wdata = '0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".p0_gnt"},    32'(p0_gnt), 0);
    chk({nm, ".p1_gnt"},    32'(p1_gnt), 0);
    chk({nm, ".mem_read"},  32'(mem_read), 0);
    chk({nm, ".mem_write"}, 32'(mem_write), 0);
    chk({nm, ".cpu_stall"}, 32'(cpu_stall), 0);
    chk({nm, ".p0_rvalid"}, 32'(p0_rvalid), 0);
    chk({nm, ".p1_rvalid"}, 32'(p1_rvalid), 0);
    chk({nm, ".p0_rdata"},  p0_rdata, 0);
    chk({nm, ".p1_rdata"},  p1_rdata, 0);
    chk({nm, ".mem_addr"},  mem_addr, 0);
    chk({nm, ".mem_wdata"}, mem_wdata, 0);
  endtask

  // Reset cycle entered at the next edge; caller releases rst_n
  task automatic do_reset();
    step();
    rst_n = 1'b0;
    idle_in();
  endtask

  // Both ports requesting from a cleared counter: p0 x4 then p1
  task automatic starve_pattern(input string nm);
    for (int k = 0; k <= LIMIT; k++) begin
      step();
      rst_n = 1'b1;
      p0_req = 1'b1; p0_we = 1'b1;
      p0_addr = 32'd200; p0_wdata = 32'(k);
      p1_req = 1'b1; p1_we = 1'b1;
      p1_addr = 32'd204; p1_wdata = 32'(k + 50);
      #1;
      chk($sformatf("%s.g0[%0d]", nm, k),
          32'(p0_gnt), 32'(k != LIMIT));
      chk($sformatf("%s.g1[%0d]", nm, k),
          32'(p1_gnt), 32'(k == LIMIT));
      chk($sformatf("%s.stall[%0d]", nm, k),
          32'(cpu_stall), 32'(k == LIMIT));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    rst_n = 1'b0;
    idle_in();

    vt[0]  = '{1,1,8,100, 0,0,0,0, 1,0,0,0,1, 8,100, 0,0,0,0};
    vt[1]  = '{1,0,8,0, 0,0,0,0, 1,0,0,1,0, 8,0, 0,0,0,0};
    vt[2]  = '{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 1,0,100,0};
    vt[3]  = '{0,0,0,0, 1,1,16,55, 0,1,0,0,1, 16,55, 0,0,0,0};
    vt[4]  = '{0,0,0,0, 1,0,16,0, 0,1,0,1,0, 16,0, 0,0,0,0};
    vt[5]  = '{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,1,0,55};
    vt[6]  = '{0,0,0,0, 1,1,24,'hA5, 0,1,0,0,1, 24,'hA5, 0,0,0,0};
    vt[7]  = '{1,0,24,0, 0,0,0,0, 1,0,0,1,0, 24,0, 0,0,0,0};
    vt[8]  = '{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 1,0,'hA5,0};
    for (int i = 9; i < 13; i++)
      vt[i] = '{1,1,32,7, 1,0,16,0, 1,0,0,0,1, 32,7, 0,0,0,0};
    vt[13] = '{1,1,32,7, 1,0,16,0, 0,1,1,1,0, 16,0, 0,0,0,0};
    vt[14] = '{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,1,0,55};
    vt[15] = '{1,0,8,0, 0,0,0,0, 1,0,0,1,0, 8,0, 0,0,0,0};
    vt[16] = '{1,0,24,0, 0,0,0,0, 1,0,0,1,0, 24,0, 1,0,100,0};
    vt[17] = '{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 1,0,'hA5,0};

    // Reset held 2 cycles with both ports requesting
    for (int c = 0; c < 2; c++) begin
      step();
      rst_n = 1'b0;
      p0_req = 1'b1; p0_we = 1'b1;
      p0_addr = 32'd40; p0_wdata = 32'h1234;
      p1_req = 1'b1; p1_we = 1'b1;
      p1_addr = 32'd44; p1_wdata = 32'h5678;
      #1;
      chk_quiet($sformatf("rst%0d", c));
    end
    starve_pattern("rel");
    chk("rst.nowrite", tb_mem[10], 0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step();
      rst_n = 1'b1;
      p0_req = vt[i].r0[0]; p0_we = vt[i].w0[0];
      p0_addr = vt[i].a0;   p0_wdata = vt[i].d0;
      p1_req = vt[i].r1[0]; p1_we = vt[i].w1[0];
      p1_addr = vt[i].a1;   p1_wdata = vt[i].d1;
      #1;
      chk($sformatf("v%0d.g0", i), 32'(p0_gnt), vt[i].g0);
      chk($sformatf("v%0d.g1", i), 32'(p1_gnt), vt[i].g1);
      chk($sformatf("v%0d.stall", i),
          32'(cpu_stall), vt[i].st);
      chk($sformatf("v%0d.mr", i), 32'(mem_read), vt[i].mr);
      chk($sformatf("v%0d.mw", i), 32'(mem_write), vt[i].mw);
      chk($sformatf("v%0d.ma", i), mem_addr, vt[i].ma);
      chk($sformatf("v%0d.md", i), mem_wdata, vt[i].md);
      chk($sformatf("v%0d.v0", i), 32'(p0_rvalid), vt[i].v0);
      chk($sformatf("v%0d.v1", i), 32'(p1_rvalid), vt[i].v1);
      if (vt[i].v0[0])
        chk($sformatf("v%0d.rd0", i), p0_rdata, vt[i].rd0);
      if (vt[i].v1[0])
        chk($sformatf("v%0d.rd1", i), p1_rdata, vt[i].rd1);
    end

    // Mid-read reset with a partially filled starve counter
    for (int c = 0; c < 2; c++) begin
      step();
      p0_req = 1'b1; p0_we = 1'b1;
      p0_addr = 32'd36; p0_wdata = 32'(c);
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd16;
    end
    step();
    idle_in();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd8;
    #1;
    chk("mrr.g0", 32'(p0_gnt), 1);
    chk("mrr.mr", 32'(mem_read), 1);
    step();
    rst_n = 1'b0;
    idle_in();
    #1;
    chk("mrr.rv0", 32'(p0_rvalid), 0);
    chk("mrr.rd0", p0_rdata, 0);
    chk("mrr.mr0", 32'(mem_read), 0);
    starve_pattern("mrr");

    do_reset();
    begin
      int streak = 0;
      logic pv0 = 1'b0, pv1 = 1'b0;
      logic pg0 = 1'b0, pg1 = 1'b0;
      logic [31:0] erd0 = '0, erd1 = '0;
      logic eg0, eg1;
      logic [31:0] ea, ed;
      logic er, ew;
      for (int cyc = 0; cyc < 400; cyc++) begin
        step();
        rst_n = 1'b1;
        if (!p0_req || pg0 || $urandom_range(0, 7) == 0) begin
          p0_req = $urandom_range(0, 2) != 0;
          p0_we = 1'($urandom_range(0, 1));
          p0_addr = 32'(64 + 4 * $urandom_range(0, 3));
          p0_wdata = $urandom;
        end
        if (!p1_req || pg1 || $urandom_range(0, 7) == 0) begin
          p1_req = $urandom_range(0, 2) != 0;
          p1_we = 1'($urandom_range(0, 1));
          p1_addr = 32'(64 + 4 * $urandom_range(0, 3));
          p1_wdata = $urandom;
        end
        eg1 = p1_req && (streak == LIMIT || !p0_req);
        eg0 = p0_req && !eg1;
        ea = eg0 ? p0_addr : eg1 ? p1_addr : 32'd0;
        ed = eg0 ? p0_wdata : eg1 ? p1_wdata : 32'd0;
        ew = (eg0 && p0_we) || (eg1 && p1_we);
        er = (eg0 && !p0_we) || (eg1 && !p1_we);
        #1;
        chk("rnd.g0", 32'(p0_gnt), 32'(eg0));
        chk("rnd.g1", 32'(p1_gnt), 32'(eg1));
        chk("rnd.stall", 32'(cpu_stall), 32'(p0_req && !eg0));
        chk("rnd.mr", 32'(mem_read), 32'(er));
        chk("rnd.mw", 32'(mem_write), 32'(ew));
        chk("rnd.ma", mem_addr, ea);
        chk("rnd.md", mem_wdata, ed);
        chk("rnd.v0", 32'(p0_rvalid), 32'(pv0));
        chk("rnd.v1", 32'(p1_rvalid), 32'(pv1));
        chk("rnd.rd0", p0_rdata, erd0);
        chk("rnd.rd1", p1_rdata, erd1);
        pv0 = eg0 && !p0_we;
        pv1 = eg1 && !p1_we;
        if (pv0) erd0 = ref_mem[ea[9:2]];
        if (pv1) erd1 = ref_mem[ea[9:2]];
        if (ew) ref_mem[ea[9:2]] = ed;
        if (!p1_req || eg1) streak = 0;
        else if (streak < LIMIT) streak++;
        pg0 = eg0;
        pg1 = eg1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (read/write port: mem_read, mem_write, addr, write_data, read_data) between two requesters.
- Port 0 is the pipeline MEM stage (CPU); port 1 is the DMA/program-loader.
- The CPU has priority, and a starvation counter guarantees forward progress for the DMA.
- The block also produces the stall signal the hazard unit uses to freeze the pipeline when the CPU is not granted.

Parameters:
- ADDR_W, 32, address width for both ports and memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive denied DMA cycles after which the DMA wins one grant; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- p0_req  in  1  CPU access request, held until granted
- p0_we  in  1  1=write, 0=read
- p0_addr  in  ADDR_W  CPU byte address
- p0_wdata  in  DATA_W  CPU write data
- p0_gnt  out  1  CPU access issued this cycle
- p0_rvalid  out  1  CPU read data valid
- p0_rdata  out  DATA_W  CPU read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as p0, for the DMA
- mem_read  out  1  read strobe to data memory
- mem_write  out  1  write strobe to data memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr while mem_read=1
- cpu_stall  out  1  p0_req & ~p0_gnt

Behaviour:
- Reset: one clock, rst_n synchronous active-low. While rst_n=0, all of the following are 0: gnt, rvalid, rdata, mem_read, mem_write, cpu_stall. mem_addr and mem_wdata are 0, and starve_cnt is 0.
- Reset mid-operation discards a pending rvalid. No memory strobe is driven during the reset cycle.
- Grant is combinational in the request cycle N. At most one gnt is high per cycle.
- Grant rule: if p1_req and starve_cnt==STARVE_LIMIT, grant p1. Otherwise, if p0_req, grant p0. Otherwise, if p1_req, grant p1. Otherwise, grant none.
- starve_cnt (registered, 8 bits):
  - Cleared when p1 is granted or p1_req=0.
  - Incremented when p1_req=1 and p1 is not granted.
  - Saturates at STARVE_LIMIT.
- Memory command is combinational from the granted port:
  - mem_write = gnt & we; mem_read = gnt & ~we.
  - mem_addr and mem_wdata are the granted port's values. With no grant they are 0 and both strobes are 0.
  - mem_read and mem_write are never both 1.
- Write completes at the rising edge ending cycle N. No response is generated for writes.
- Read: mem_rdata is captured at the end of cycle N into the granted port's rdata register.
  - That port's rvalid is 1 for exactly cycle N+1.
  - rdata holds its value until the next read for that port.
  - The other port's rdata is unchanged.
  - Latency grant-to-rvalid is 1 cycle. Back-to-back reads give rvalid every cycle.
- Requesters keep req/we/addr/wdata stable until gnt. Deasserting req before gnt is legal; the request is simply dropped.
- A port may issue a new request in the cycle after its grant; it needs no wait for rvalid.
- Simultaneous p0 read and p1 write to the same address: order follows grant order. A read in a later cycle sees the earlier write.
- Address is passed unchanged; no range check or alignment in this block.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with p0_req=p1_req=1 -> all outputs 0, no mem_write pulse. After release, p0_gnt=1 in the first cycle.
- CPU write/read: p0 write 100 to addr 8, then p0 read addr 8 -> p0_gnt in the same cycle as req, mem_write one cycle, p0_rvalid=1 one cycle later, p0_rdata=100, cpu_stall=0 throughout.
- DMA alone: p1 writes 55 to addr 16, then reads it -> p1_gnt immediate, p1_rdata=55 with p1_rvalid one cycle after grant, p0_rvalid stays 0.
- Starvation (STARVE_LIMIT=4): p0_req and p1_req held high continuously -> grant pattern p0,p0,p0,p0,p1 repeating. cpu_stall=1 exactly on the p1-grant cycles.
- Same-address ordering: p1 write 0xA5 to addr 24 granted in cycle N, p0 read addr 24 granted in N+1 -> p0_rdata=0xA5.
- Mid-read reset: p0 read granted, rst_n=0 in the next cycle -> p0_rvalid=0 in that cycle, and starve_cnt=0 afterwards.
